bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
// PURPOSE
//   Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble).
//   Generalises the fixed 5-bit (carry + 4-bit sum) to two-digit combinational converter
//   to any BIN_W-bit input and DIGITS-digit output, with start/busy/done handshake.
//   Adds decimal-overflow detection when DIGITS is too small for the value.
//   Sits between adder/counter datapaths and seven-segment digit decoders.
// PARAMETERS
//   BIN_W   8  width of unsigned binary input; >= 1
//   DIGITS  3  number of BCD output digits; >= 1; may be smaller than ceil(BIN_W*log10(2))
// PORTS
//   clk       in   1           rising-edge clock; sole clock
//   reset     in   1           synchronous, active-high reset
//   start     in   1           request conversion of bin_in; honoured only when idle
//   bin_in    in   BIN_W       unsigned binary operand, sampled on accepted start
//   busy      out  1           conversion in progress
//   done      out  1           one-cycle pulse: bcd_out/overflow updated this cycle
//   bcd_out   out  4*DIGITS    result; digit k at [4k+3:4k], digit 0 = units
//   overflow  out  1           1 = bin_in >= 10**DIGITS; bcd_out holds value mod 10**DIGITS
// BEHAVIOUR
//   Reset (sampled on clk edge with reset=1): state=IDLE, busy=0, done=0, bcd_out=0,
//     overflow=0, internal shift/scratch/counter regs=0. Reset wins over start in same cycle.
//   States: IDLE, CONV.
//   IDLE: busy=0. start=1 at an edge -> latch bin_in into shift reg, clear BCD scratch
//     and sticky ovf, iteration count=0, go CONV. start=0 -> stay.
//   CONV: busy=1. Each cycle = one iteration: (a) every scratch digit (incl. top digit)
//     >= 5 gets +3 (4-bit); (b) {scratch, shift} shifted left 1; bit leaving top of scratch
//     ORed into sticky ovf. Count increments; after BIN_W iterations -> IDLE.
//   Completion edge (end of BIN_W-th CONV cycle): bcd_out <= final scratch,
//     overflow <= sticky ovf, done <= 1, busy <= 0, state <= IDLE.
//   done is 1 for exactly one cycle; 0 in all others.
//   Latency: start sampled at edge 0 -> busy=1 cycles 1..BIN_W -> done=1 in cycle BIN_W+1.
//   Back-to-back: start=1 during the done cycle is accepted (state already IDLE).
//   start while busy: ignored, no effect on operand or timing; no queueing.
//   bin_in changes while busy: ignored (operand latched at accept).
//   bcd_out/overflow hold last result between done pulses; not cleared on new start.
//   Reset mid-CONV: conversion abandoned; no done pulse; all outputs to reset values.
//   Arithmetic: unsigned only; every digit in bcd_out is 0..9 whenever done=1.
//   Iteration counter width: $clog2(BIN_W+1) bits.
// TESTING
//   1. BIN_W=8,DIGITS=3: start, bin_in=8'd255 -> busy 8 cycles, done in cycle 9,
//      bcd_out=12'h255, overflow=0.
//   2. bin_in=0 then bin_in=19 (start on done cycle) -> bcd_out=12'h000, then 12'h019
//      exactly 9 cycles later; overflow=0 both.
//   3. DIGITS=2, bin_in=8'd123 -> bcd_out=8'h23, overflow=1; next bin_in=99 -> 8'h99,
//      overflow=0.
//   4. start pulsed with bin_in=200 on cycles 3 and 5 after accepting bin_in=42 ->
//      single done, bcd_out=12'h042, timing unchanged.
//   5. reset=1 in cycle 4 of conversion of 255 -> busy=0, done never pulses, bcd_out=0;
//      new start with 7 -> 12'h007.
//   6. BIN_W=16,DIGITS=5: 16'd65535 -> 20'h65535 after 17 cycles; random sweep vs
//      reference model.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq_if
// Description : Start/busy/done handshake and result bus of the converter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bin2bcd_seq_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [BIN_W-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  overflow;

   modport master (
      output start,
      output bin_in,
      input  busy,
      input  done,
      input  bcd_out,
      input  overflow
   );

   modport slave (
      input  start,
      input  bin_in,
      output busy,
      output done,
      output bcd_out,
      output overflow
   );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble binary-to-BCD converter, one bit/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic            clk,
   input  logic            reset,
   bin2bcd_seq_if.slave    bus
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(BIN_W - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [BIN_W-1:0]  r_shift, w_shift_nxt, w_shift_sh;
   logic [BCD_W-1:0]  r_scratch, w_scratch_nxt, w_adj, w_scratch_sh;
   logic [BCD_W-1:0]  r_bcd, w_bcd_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_ovf_s, w_ovf_s_nxt;
   logic              r_ovf, w_ovf_nxt;
   logic              r_done, w_done_nxt;

   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_digit
         assign w_adj[4*k +: 4] = (r_scratch[4*k +: 4] >= 4'd5) ?
                                  r_scratch[4*k +: 4] + 4'd3 : r_scratch[4*k +: 4];
      end
   endgenerate

   // A bit leaving the top digit carries weight 10**DIGITS: the value no longer fits.
   assign w_scratch_sh = {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
   assign w_shift_sh   = r_shift << 1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_scratch <= '0;
         r_cnt     <= '0;
         r_ovf_s   <= 1'b0;
         r_bcd     <= '0;
         r_ovf     <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_scratch <= w_scratch_nxt;
         r_cnt     <= w_cnt_nxt;
         r_ovf_s   <= w_ovf_s_nxt;
         r_bcd     <= w_bcd_nxt;
         r_ovf     <= w_ovf_nxt;
         r_done    <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_scratch_nxt = r_scratch;
      w_cnt_nxt     = r_cnt;
      w_ovf_s_nxt   = r_ovf_s;
      w_bcd_nxt     = r_bcd;
      w_ovf_nxt     = r_ovf;
      w_done_nxt    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_shift_nxt   = bus.bin_in;
               w_scratch_nxt = '0;
               w_cnt_nxt     = '0;
               w_ovf_s_nxt   = 1'b0;
               w_state_nxt   = CONV;
            end
         end
         CONV: begin
            w_shift_nxt   = w_shift_sh;
            w_scratch_nxt = w_scratch_sh;
            w_ovf_s_nxt   = r_ovf_s | w_adj[BCD_W-1];
            w_cnt_nxt     = r_cnt + CNT_W'(1);
            if (r_cnt == c_LAST) begin
               w_bcd_nxt   = w_scratch_sh;
               w_ovf_nxt   = r_ovf_s | w_adj[BCD_W-1];
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.busy     = (r_state == CONV);
   assign bus.done     = r_done;
   assign bus.bcd_out  = r_bcd;
   assign bus.overflow = r_ovf;
endmodule
`default_nettype wire
